case_7_mac_acc: RTL
===================

# case_7_mac_acc

Downstream consumer of the case_7 signed product stage. Accepts a stream of 13-bit signed products over a valid/ready handshake and accumulates a frame of `len` products at full precision. Emits one saturated 16-bit sum per frame through a registered valid/ready output. Frames are started and completed with ap_start/ap_idle/ap_done control.

## Interface
- PROD_W, 13: product input width, signed two's complement
- ACC_W, 20: internal accumulator width; must be ≥ PROD_W + log2(MAX_LEN), so it never overflows
- OUT_W, 16: result width, signed and saturated
- MAX_LEN, 64: maximum products per frame
- LEN_W, 7: width of len; must hold MAX_LEN
- ap_clk  in  1  single clock, rising edge
- ap_rst  in  1  asynchronous, active-high reset
- ap_start  in  1  frame start request; sampled only in IDLE
- len  in  LEN_W  products in frame, sampled with ap_start; values above MAX_LEN are clamped to MAX_LEN
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse when the result is consumed
- prod_din  in  PROD_W  signed product from the multiplier stage
- prod_vld  in  1  prod_din valid
- prod_rdy  out  1  block accepts prod_din
- sum_dout  out  OUT_W  saturated frame sum
- sum_sat  out  1  high if sum_dout was clipped
- sum_vld  out  1  result valid
- sum_rdy  in  1  downstream accepts result

## Operation
- States:
  - IDLE: ap_idle=1, prod_rdy=0, sum_vld=0.
  - ACC: prod_rdy=1.
  - OUT: sum_vld=1, prod_rdy=0.
- IDLE→ACC on ap_start with len≠0. On that edge: latch the clamped len, acc:=0, cnt:=0.
- IDLE→OUT on ap_start with len=0. On that edge: sum_dout:=0, sum_sat:=0.
- ACC: each transfer (prod_vld & prod_rdy) does acc += sign-extend(prod_din) and cnt += 1. No transfer means no change.
- ACC→OUT on the transfer where cnt == len_latched−1. On that edge, sum_dout and sum_sat are registered from the final sum (acc + the last product).
- Saturation of the final sum:
  - above 2^(OUT_W−1)−1 → 32767, sum_sat=1
  - below −2^(OUT_W−1) → −32768, sum_sat=1
  - otherwise the low OUT_W bits, sum_sat=0
- OUT: sum_dout, sum_sat and sum_vld hold stable until sum_rdy. On sum_vld & sum_rdy: go to IDLE and pulse ap_done for the next cycle.
- ap_start outside IDLE is ignored. len changes outside IDLE are ignored.
- prod_vld in IDLE or OUT is not accepted; prod_rdy stays 0.
- Reset (any time, including mid-frame): state=IDLE, acc=0, cnt=0, len_latched=0, sum_dout=0, sum_sat=0, sum_vld=0, prod_rdy=0, ap_done=0, ap_idle=1. A partial frame is discarded.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Throughput: one product per cycle while prod_vld is held high.
- Latency: the transfer of the last product at edge k gives sum_vld=1 in the cycle after edge k.
- Minimum frame time is len + 2 cycles: start edge, len transfer edges, then the output handshake edge if sum_rdy is already high.
- ap_done is high for exactly one cycle, the cycle after the output handshake. ap_idle is high in that same cycle.
- A new ap_start may be issued in the same cycle as ap_done and is accepted.
- Bubbles: prod_vld may drop for any number of cycles mid-frame; acc and cnt hold.
- Backpressure: sum_rdy low for any number of cycles holds OUT with all outputs stable.

## Test plan
- len=4, products 100, −50, 4095, −4096, back-to-back → sum_vld one cycle after the 4th transfer, sum_dout=49, sum_sat=0, ap_done one cycle after sum_rdy.
- len=10, all products 4095 → sum_dout=32767, sum_sat=1. Then len=10, all −4096 → sum_dout=−32768, sum_sat=1.
- len=3, products 7, 8, 9, with prod_vld toggled 1-0-0-1-0-1 and sum_rdy held low for 5 cycles → sum_dout=24 held stable for all 5 cycles, no extra transfers, one ap_done.
- len=0 with ap_start → IDLE→OUT directly, sum_dout=0, sum_sat=0, prod_rdy never high.
- len=64 with products alternating 4095 and −4096 → sum_dout=−32, sum_sat=0. Also len=100 → clamped to 64, prod_rdy drops after exactly 64 transfers.
- ap_rst asserted after 2 of 5 products, then ap_start with len=2, products 1, 2 → all outputs at reset values during reset, new frame gives sum_dout=3. Also ap_start pulsed during ACC is ignored.

Source files
------------

// File: rtl/case_7_mac_acc_if.sv
// Control, product-stream and result-stream bundle for the frame accumulator.
// The master drives requests and products; the slave is the accumulator.
interface case_7_mac_acc_if #(
  parameter int PROD_W = 13,
  parameter int OUT_W  = 16,
  parameter int LEN_W  = 7
);
  logic              ap_start;
  logic [LEN_W-1:0]  len;
  logic              ap_idle;
  logic              ap_done;
  logic [PROD_W-1:0] prod_din;
  logic              prod_vld;
  logic              prod_rdy;
  logic [OUT_W-1:0]  sum_dout;
  logic              sum_sat;
  logic              sum_vld;
  logic              sum_rdy;

  modport master (
    output ap_start, len, prod_din, prod_vld, sum_rdy,
    input  ap_idle, ap_done, prod_rdy,
    input  sum_dout, sum_sat, sum_vld
  );

  modport slave (
    input  ap_start, len, prod_din, prod_vld, sum_rdy,
    output ap_idle, ap_done, prod_rdy,
    output sum_dout, sum_sat, sum_vld
  );
endinterface

// File: rtl/case_7_mac_acc.sv
// Frame accumulator: sums len signed products at full precision and
// returns one saturated result per frame over a registered handshake.
module case_7_mac_acc #(
  parameter int PROD_W  = 13,
  parameter int ACC_W   = 20,
  parameter int OUT_W   = 16,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic            ap_clk,
  input  logic            ap_rst,
  case_7_mac_acc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [OUT_W-1:0]        sum_q, sum_d;
  logic                    sat_q, sat_d;
  logic                    done_q, done_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_full;
  logic [LEN_W-1:0]        len_clamp;
  logic [OUT_W-1:0]        sat_val;
  logic                    sat_flag;
  logic                    xfer;
  logic                    last;
  logic                    out_hs;

  assign prod_ext = {{(ACC_W - PROD_W){bus.prod_din[PROD_W-1]}},
                     bus.prod_din};
  assign sum_full = acc_q + prod_ext;

  assign len_clamp = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

  assign xfer   = (state_q == S_ACC) & bus.prod_vld;
  assign last   = (cnt_q == len_q - LEN_W'(1));
  assign out_hs = (state_q == S_OUT) & bus.sum_rdy;

  // Clip the running sum plus the incoming product to the result range.
  always_comb begin
    sat_val  = sum_full[OUT_W-1:0];
    sat_flag = 1'b0;
    if (sum_full > SAT_HI) begin
      sat_val  = SAT_HI[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (sum_full < SAT_LO) begin
      sat_val  = SAT_LO[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    done_d  = out_hs;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          if (bus.len == '0) begin
            state_d = S_OUT;
            sum_d   = '0;
            sat_d   = 1'b0;
          end else begin
            state_d = S_ACC;
            len_d   = len_clamp;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      S_ACC: begin
        if (xfer) begin
          acc_d = sum_full;
          cnt_d = cnt_q + LEN_W'(1);
          if (last) begin
            state_d = S_OUT;
            sum_d   = sat_val;
            sat_d   = sat_flag;
          end
        end
      end
      S_OUT: begin
        if (bus.sum_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign bus.ap_idle  = (state_q == S_IDLE);
  assign bus.prod_rdy = (state_q == S_ACC);
  assign bus.sum_vld  = (state_q == S_OUT);
  assign bus.ap_done  = done_q;
  assign bus.sum_dout = sum_q;
  assign bus.sum_sat  = sat_q;

endmodule
